// File: rtl/ps2_keys_pkg.sv
// PS/2 set-2 key definitions shared by the scancode encoder and the keyboard decoder:
// key index constants, the make-code table and the break prefix.
package ps2_keys_pkg;

  localparam int NUM_KEYS_DEFAULT = 29;
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  localparam int KEY_TILDE = 0,  KEY_1 = 1,  KEY_2 = 2,  KEY_3 = 3,  KEY_4 = 4;
  localparam int KEY_5 = 5,  KEY_6 = 6,  KEY_7 = 7,  KEY_8 = 8,  KEY_9 = 9;
  localparam int KEY_0 = 10, KEY_MINUS = 11, KEY_EQUALS = 12, KEY_BKSP = 13;
  localparam int KEY_TAB = 14, KEY_Q = 15, KEY_W = 16, KEY_E = 17, KEY_R = 18;
  localparam int KEY_T = 19, KEY_Y = 20, KEY_U = 21, KEY_I = 22, KEY_O = 23;
  localparam int KEY_P = 24, KEY_LBRACKET = 25, KEY_RBRACKET = 26;
  localparam int KEY_BSLASH = 27, KEY_SPACE = 28;

  localparam logic [7:0] KEY_CODES [NUM_KEYS_DEFAULT] = '{
    8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h45, 8'h4E, 8'h55, 8'h66, 8'h0D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h29
  };

  typedef enum logic [1:0] {
    SCAN,
    SEND_BREAK,
    SEND_CODE
  } encState_t;

  // Keys beyond the table have no scancode; 8'h00 means "update silently".
  function automatic logic [7:0] keyCode(input logic [7:0] idx);
    logic [7:0] code;
    code = 8'h00;
    if (idx < 8'(NUM_KEYS_DEFAULT)) code = KEY_CODES[idx[4:0]];
    return code;
  endfunction

endpackage

// File: rtl/scancode_encoder_if.sv
// Byte stream handshake between the scancode encoder (master) and its consumer.
interface scancode_encoder_if;
  logic [7:0] byteOut;
  logic       byteValid;
  logic       byteReady;

  modport master (output byteOut, output byteValid, input byteReady);
  modport slave  (input byteOut, input byteValid, output byteReady);
endinterface

// File: rtl/typematic_timer.sv
// Auto-repeat timer for the scancode encoder; only built with SCANCODE_TYPEMATIC_EN.
`ifdef SCANCODE_TYPEMATIC_EN
module typematic_timer #(
  parameter int DELAY  = 25_000_000,
  parameter int PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic cancel,
  input  logic consume,
  output logic due
);
  logic [31:0] countReg;
  logic        armedReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      countReg <= '0;
      armedReg <= 1'b0;
    end else if (start) begin
      armedReg <= 1'b1;
      countReg <= 32'(DELAY - 1);
    end else if (cancel) begin
      armedReg <= 1'b0;
    end else if (consume) begin
      countReg <= 32'(PERIOD - 1);
    end else if (armedReg && countReg != 32'd0) begin
      countReg <= countReg - 32'd1;
    end
  end

  assign due = armedReg && (countReg == 32'd0);
endmodule
`endif

// File: rtl/scancode_encoder.sv
// Scans keyState against the last transmitted state and emits PS/2 make/break bytes.
// Optional auto-repeat of the last pressed key is enabled by SCANCODE_TYPEMATIC_EN.
module scancode_encoder
  import ps2_keys_pkg::*;
#(
  parameter int NUM_KEYS         = NUM_KEYS_DEFAULT,
  parameter int TYPEMATIC_DELAY  = 25_000_000,
  parameter int TYPEMATIC_PERIOD = 5_000_000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keyState,
  output logic                busy,
  scancode_encoder_if.master  byteBus
);
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  encState_t           stateReg;
  idx_t                idxReg;
  idx_t                latchIdxReg;
  logic                latchDirReg;
  logic [NUM_KEYS-1:0] shadowReg;
  logic [7:0]          byteOutReg;
  logic                byteValidReg;

  function automatic idx_t nextIdx(input idx_t i);
    return (i == idx_t'(NUM_KEYS - 1)) ? '0 : i + 1'b1;
  endfunction

  logic       mismatch;
  logic       transfer;
  logic [7:0] scanCode;
  logic [7:0] latchCode;

  assign mismatch  = keyState[idxReg] != shadowReg[idxReg];
  assign transfer  = byteValidReg && byteBus.byteReady;
  assign scanCode  = keyCode(8'(idxReg));
  assign latchCode = keyCode(8'(latchIdxReg));

`ifdef SCANCODE_TYPEMATIC_EN
  logic repeatDue;
  logic repeatReg;
  idx_t repeatIdxReg;
  logic issueRepeat;
  logic codeDone;

  assign codeDone    = (stateReg == SEND_CODE) && transfer && !repeatReg;
  assign issueRepeat = (stateReg == SCAN) && !mismatch && repeatDue && keyState[repeatIdxReg];

  typematic_timer #(
    .DELAY  (TYPEMATIC_DELAY),
    .PERIOD (TYPEMATIC_PERIOD)
  ) timer (
    .clk     (CLOCK_50),
    .reset   (reset),
    .start   (codeDone && latchDirReg),
    .cancel  (codeDone && !latchDirReg && latchIdxReg == repeatIdxReg),
    .consume (issueRepeat),
    .due     (repeatDue)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      repeatReg    <= 1'b0;
      repeatIdxReg <= '0;
    end else begin
      if (issueRepeat) repeatReg <= 1'b1;
      else if (stateReg == SEND_CODE && transfer) repeatReg <= 1'b0;
      if (codeDone && latchDirReg) repeatIdxReg <= latchIdxReg;
    end
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      stateReg     <= SCAN;
      idxReg       <= '0;
      latchIdxReg  <= '0;
      latchDirReg  <= 1'b0;
      shadowReg    <= '0;
      byteOutReg   <= 8'h00;
      byteValidReg <= 1'b0;
    end else begin
      case (stateReg)
        SCAN: begin
          if (mismatch) begin
            latchIdxReg <= idxReg;
            latchDirReg <= keyState[idxReg];
            if (scanCode == 8'h00) begin
              shadowReg[idxReg] <= keyState[idxReg];
              idxReg            <= nextIdx(idxReg);
            end else begin
              byteValidReg <= 1'b1;
              byteOutReg   <= keyState[idxReg] ? scanCode : BREAK_PREFIX;
              stateReg     <= keyState[idxReg] ? SEND_CODE : SEND_BREAK;
            end
`ifdef SCANCODE_TYPEMATIC_EN
          end else if (issueRepeat) begin
            latchIdxReg  <= repeatIdxReg;
            latchDirReg  <= 1'b1;
            byteOutReg   <= keyCode(8'(repeatIdxReg));
            byteValidReg <= 1'b1;
            stateReg     <= SEND_CODE;
`endif
          end else begin
            idxReg <= nextIdx(idxReg);
          end
        end
        SEND_BREAK: begin
          if (transfer) begin
            byteOutReg <= latchCode;
            stateReg   <= SEND_CODE;
          end
        end
        SEND_CODE: begin
          if (transfer) begin
            byteValidReg <= 1'b0;
            stateReg     <= SCAN;
`ifdef SCANCODE_TYPEMATIC_EN
            // Repeats leave the scan position and the transmitted state untouched.
            if (!repeatReg) begin
              shadowReg[latchIdxReg] <= latchDirReg;
              idxReg                 <= nextIdx(latchIdxReg);
            end
`else
            shadowReg[latchIdxReg] <= latchDirReg;
            idxReg                 <= nextIdx(latchIdxReg);
`endif
          end
        end
        default: stateReg <= SCAN;
      endcase
    end
  end

  assign busy              = stateReg != SCAN;
  assign byteBus.byteOut   = byteOutReg;
  assign byteBus.byteValid = byteValidReg;
endmodule

// File: doc/scancode_encoder.md
SCANCODE_ENCODER -- requirements
Module: scancode_encoder

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 29, number of tracked keys.
REQ-002 SHALL have parameter TYPEMATIC_DELAY, default 25_000_000, CLOCK_50 cycles from press to first repeat.
REQ-003 SHALL have parameter TYPEMATIC_PERIOD, default 5_000_000, CLOCK_50 cycles between repeats.
REQ-004 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 keyState  in  NUM_KEYS  level state per key, 1=held, indexed per the shared key table.
REQ-007 byteOut  out  8  scancode byte to transmit.
REQ-008 byteValid  out  1  byteOut holds a byte awaiting acceptance.
REQ-009 byteReady  in  1  consumer accepts byteOut this cycle when byteValid is high.
REQ-010 busy  out  1  high when not in SCAN state.

Function
REQ-011 SHALL count a transfer only on a cycle with byteValid=1 and byteReady=1; while byteValid=1, byteOut SHALL stay constant.
REQ-012 SHALL keep a NUM_KEYS-bit shadow register of the last key state transmitted.
REQ-013 FSM states SHALL be SCAN, SEND_BREAK, SEND_CODE.
REQ-014 In SCAN, index idx SHALL advance by one per cycle, wrapping from NUM_KEYS-1 to 0.
REQ-015 In SCAN, if keyState[idx]!=shadow[idx], SHALL latch idx and direction, hold idx, and move next cycle to SEND_CODE (press) or SEND_BREAK (release).
REQ-016 SEND_BREAK SHALL present 8'hF0 and, on transfer, go to SEND_CODE.
REQ-017 SEND_CODE SHALL present the table scancode of the latched idx; on transfer it SHALL write the latched direction into shadow[idx], advance idx by one, and return to SCAN.
REQ-018 byteValid SHALL rise exactly one cycle after the SCAN cycle that detected the mismatch.
REQ-019 Multiple simultaneous changes SHALL be sent one key at a time, in scan order starting from the current idx.
REQ-020 A key that toggles and returns to its shadow value before idx reaches it SHALL produce no bytes.
REQ-021 keyState changes on the latched key during SEND_* SHALL be ignored; any residual mismatch SHALL be sent on a later pass.
REQ-022 Indices NUM_KEYS and above SHALL never be visited; a table entry of 8'h00 SHALL update shadow silently, with no byte sent.

Reset
REQ-023 On reset: shadow=0, idx=0, state=SCAN, byteOut=8'h00, byteValid=0, busy=0, typematic counter and armed flag cleared.
REQ-024 Reset during SEND_* SHALL drop the pending byte, with no partial F0/code pair completed afterwards.

Configuration
REQ-025 Macro SCANCODE_TYPEMATIC_EN: when defined, the most recently pressed key SHALL re-send its make code after TYPEMATIC_DELAY and then every TYPEMATIC_PERIOD cycles while it remains held.
REQ-026 A repeat SHALL be issued only from SCAN on a cycle with no mismatch at idx, through SEND_CODE, without changing shadow.
REQ-027 A repeat SHALL be cancelled by release of that key or by a press of any other key, and the counter SHALL restart at the new press.
REQ-028 When the macro is undefined, no counter or repeat logic SHALL exist, and each press SHALL yield exactly one make code.

Structure
REQ-029 Shared package ps2_keys_pkg SHALL hold NUM_KEYS_DEFAULT, BREAK_PREFIX=8'hF0, and the key scancode table: 0E,16,1E,26,25,2E,36,3D,3E,46,45,4E,55,66,0D,15,1D,24,2D,2C,35,3C,43,44,4D,54,5B,5D,29 for index 0..28 (tilde..space).
REQ-030 The package SHALL also hold the key index constants shared with the keyboard decoder.
REQ-031 One sub-module, typematic_timer, SHALL contain the repeat counter and exist only under SCANCODE_TYPEMATIC_EN.

Verification
REQ-032 Reset, hold keyState=0 for 100 cycles, byteReady=1 -> byteValid never rises, busy=0.
REQ-033 Set keyState[15] (Q), byteReady=1 -> exactly one byte 8'h15; shadow[15]=1.
REQ-034 Clear keyState[15], byteReady held 0 for 10 cycles then 1 -> byteOut stable 8'hF0 throughout the stall, then 8'hF0, 8'h15 transferred in order.
REQ-035 Set bits 0 and 28 together with idx=5 -> 8'h29 then 8'h0E; bit 3 pulsed for 2 cycles while idx is busy at 28 -> no bytes for key 3.
REQ-036 Assert reset after 8'hF0 is accepted but before its code -> byteValid=0 next cycle; no 8'h2D follows; shadow=0.
REQ-037 With SCANCODE_TYPEMATIC_EN, DELAY=100, PERIOD=20, hold key 28 for 150 cycles -> make codes 8'h29 at roughly cycles 0, 100, 120, 140; release -> 8'hF0, 8'h29; no further repeats.
